uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmit line among NREQ byte requesters.
//  A round-robin arbiter picks one pending requester, latches its byte and serialises it as 1 start / DBIT data / 1 stop.
//  Bit timing comes from the s_tick oversampling strobe produced by the baud-rate generator (OS ticks per bit).
//  Sits between the on-chip byte producers (console, debug, status) and the tx pin.
// PARAMETERS
//  NREQ     4   number of requesters (>=2)
//  IDW      2   width of owner index, = clog2(NREQ)
//  DBIT     8   data bits per frame
//  OS       16  s_tick pulses per start/data bit
//  SB_TICK  16  s_tick pulses for the stop bit (16 = 1 stop, 24 = 1.5 stop, 32 = 2 stop)
// PORTS
//  clk       in   1          system clock, rising edge
//  reset     in   1          asynchronous, active-high
//  s_tick    in   1          one-clk oversampling strobe from the baud-rate generator
//  req       in   NREQ       req[i]=1: requester i holds a byte on din
//  din       in   NREQ*DBIT  requester i's byte at din[i*DBIT +: DBIT]
//  gnt       out  NREQ       one-hot, one-clk pulse: byte of requester i accepted
//  owner     out  IDW        index of the requester whose frame is on the line
//  busy      out  1          1 from the grant cycle until the cycle after the stop bit ends
//  done_tick out  1          one-clk pulse on the last stop-bit tick
//  tx        out  1          serial output, idle high
// BEHAVIOUR
//  Reset (asynchronous): tx=1, gnt=0, busy=0, done_tick=0, owner=0, state=IDLE, rr pointer=0, counters=0.
//    All outputs are registered, so tx goes to 1 immediately on reset.
//  FSM states: IDLE, START, DATA, STOP.
//  IDLE with req!=0:
//    - Grant the first set req[i] scanning i = ptr, ptr+1, ... modulo NREQ.
//    - In that cycle: gnt[i]=1, latch din slice into shift register b, owner<=i, ptr<=(i+1) mod NREQ, busy<=1.
//    - Clear tick counter s and bit counter n, go to START.
//  Handshake:
//    - Requester holds req and din stable until it sees gnt[i].
//    - Dropping req before gnt withdraws the request with no side effect.
//    - req still high in the cycle after gnt is a new request.
//  Tick counting:
//    - s advances only on s_tick=1 and holds otherwise.
//    - s_tick in the grant cycle is ignored.
//    - The first counted tick is the first s_tick after the grant cycle.
//  START: tx=0. On the tick where s==OS-1: s<=0, go to DATA.
//  DATA: tx=b[0] (LSB first). On the tick where s==OS-1: s<=0, b<=b>>1.
//    - If n==DBIT-1, go to STOP; else n<=n+1.
//  STOP: tx=1. On the tick where s==SB_TICK-1: done_tick=1 for one clk, go to IDLE.
//    - busy drops in the following cycle.
//  Back-to-back: the earliest next grant is the first IDLE cycle, giving at least one clk of idle-high line between frames.
//  Fairness: with all req held, grants rotate 0,1,..,NREQ-1,0; no requester waits more than NREQ-1 frames.
//  Counter widths: s holds max(OS,SB_TICK)-1; n holds DBIT-1. No wrap beyond the terminal values.
//  Reset mid-frame: frame abandoned, tx=1 at once, no gnt or done_tick; the requester's byte is lost.
//  s_tick stuck low: FSM holds state, outputs stable; no timeout.
// STRUCTURE
//  Shared header uart_defs.vh: FSM state encodings, default OS=16, SB_TICK presets for 1, 1.5 and 2 stop bits.
//  Sub-module uart_tx_serializer: START/DATA/STOP shifter with tx_start/din/s_tick in and tx/tx_done_tick out.
//  This module keeps the round-robin arbiter, ptr, owner and busy.
// TESTING  (NREQ=4, DBIT=8, OS=16, SB_TICK=16, s_tick every 4th clk)
//  1. Reset, req=0 -> tx=1, busy=0, gnt=0, done_tick=0 for 1000 clks.
//  2. req=4'b0100, din slice2=8'hA5 -> gnt=4'b0100 for one clk, owner=2.
//     tx: 0 for 16 ticks, then 1,0,1,0,0,1,0,1 at 16 ticks each, then 1 for 16 ticks.
//     done_tick one pulse, busy falls next clk.
//  3. req=4'b1111 held, distinct bytes -> grant order 0,1,2,3,0.
//     Each frame carries the matching byte; exactly 1 idle clk between frames.
//  4. After grant to 1 (ptr=2), req=4'b1010 -> next grant 3, then 1.
//  5. Reset asserted during DATA bit 3 -> tx=1 same cycle.
//     After release: IDLE, ptr=0, no done_tick; a new req produces a clean frame.
//  6. s_tick=1 in the grant cycle and held continuously -> start bit exactly 16 clks.
//     Also: req[0] dropped before gnt -> no grant, tx stays 1.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler_pkg
//  Description : Shared types and constants for the UART transmit scheduler:
//                serializer state encoding, oversampling and stop-bit presets,
//                and small sizing helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_tx_scheduler_pkg;

   // Serializer line states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Default oversampling ratio and stop-bit lengths in s_tick pulses
   localparam int c_OS_DEFAULT   = 16;
   localparam int c_SB_TICK_1    = 16;
   localparam int c_SB_TICK_1P5  = 24;
   localparam int c_SB_TICK_2    = 32;

   // Larger of two integers, used to size the shared tick counter
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold values 0..n-1, never less than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : uart_tx_scheduler_pkg
`default_nettype wire

// File: rtl/uart_tx_scheduler_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler_serializer
//  Description : Start / DBIT data (LSB first) / stop shifter timed by the
//                s_tick oversampling strobe. tx and done_tick are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler_serializer
   import uart_tx_scheduler_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int OS      = c_OS_DEFAULT,
   parameter int SB_TICK = c_SB_TICK_1
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_start,
   input  logic [DBIT-1:0] i_din,
   input  logic            i_s_tick,
   output logic            o_tx,
   output logic            o_done_tick,
   output logic            o_idle
);

   localparam int c_SW = cnt_width(max2(OS, SB_TICK));
   localparam int c_NW = cnt_width(DBIT);
   localparam logic [c_SW-1:0] c_OS_LAST   = c_SW'(OS - 1);
   localparam logic [c_SW-1:0] c_SB_LAST   = c_SW'(SB_TICK - 1);
   localparam logic [c_NW-1:0] c_BIT_LAST  = c_NW'(DBIT - 1);

   tx_state_t       r_state, w_state_nxt;
   logic [c_SW-1:0] r_s, w_s_nxt;
   logic [c_NW-1:0] r_n, w_n_nxt;
   logic [DBIT-1:0] r_b, w_b_nxt;
   logic            r_tx, w_tx_nxt;
   logic            r_done, w_done_nxt;

   // State, counters, shift register and registered line outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_n     <= w_n_nxt;
         r_b     <= w_b_nxt;
         r_tx    <= w_tx_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state logic; tx is derived from the state being entered so the
   // registered line level always matches the registered state
   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_n_nxt     = r_n;
      w_b_nxt     = r_b;
      w_done_nxt  = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            // A tick coinciding with the start request is deliberately not counted
            if (i_start) begin
               w_b_nxt     = i_din;
               w_s_nxt     = '0;
               w_n_nxt     = '0;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (i_s_tick) begin
               if (r_s == c_OS_LAST) begin
                  w_s_nxt     = '0;
                  w_state_nxt = ST_DATA;
               end else begin
                  w_s_nxt = r_s + c_SW'(1);
               end
            end
         end
         ST_DATA: begin
            if (i_s_tick) begin
               if (r_s == c_OS_LAST) begin
                  w_s_nxt = '0;
                  w_b_nxt = r_b >> 1;
                  if (r_n == c_BIT_LAST) begin
                     w_state_nxt = ST_STOP;
                  end else begin
                     w_n_nxt = r_n + c_NW'(1);
                  end
               end else begin
                  w_s_nxt = r_s + c_SW'(1);
               end
            end
         end
         ST_STOP: begin
            if (i_s_tick) begin
               if (r_s == c_SB_LAST) begin
                  w_s_nxt     = '0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_s_nxt = r_s + c_SW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      case (w_state_nxt)
         ST_START: w_tx_nxt = 1'b0;
         ST_DATA:  w_tx_nxt = w_b_nxt[0];
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   assign o_tx        = r_tx;
   assign o_done_tick = r_done;
   assign o_idle      = (r_state == ST_IDLE);

endmodule : uart_tx_scheduler_serializer
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Round-robin arbitration of NREQ byte requesters onto one
//                UART transmit line. Keeps the rotating pointer, owner index,
//                grant pulse and busy flag; framing is done by the serializer.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int DBIT    = 8,
   parameter int OS      = c_OS_DEFAULT,
   parameter int SB_TICK = c_SB_TICK_1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_tick,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DBIT-1:0] din,
   output logic [NREQ-1:0]      gnt,
   output logic [IDW-1:0]       owner,
   output logic                 busy,
   output logic                 done_tick,
   output logic                 tx
);

   localparam int               c_SUMW     = IDW + 1;
   localparam logic [IDW:0]     c_NREQ_W   = c_SUMW'(NREQ);
   localparam logic [IDW-1:0]   c_LAST_IDX = IDW'(NREQ - 1);

   logic [NREQ-1:0] r_gnt;
   logic [IDW-1:0]  r_owner;
   logic [IDW-1:0]  r_ptr;
   logic            r_busy;

   logic            w_found;
   logic [IDW-1:0]  w_idx;
   logic [IDW:0]    w_sum;
   logic [IDW-1:0]  w_cand;
   logic [IDW-1:0]  w_ptr_nxt;
   logic [DBIT-1:0] w_din_sel;
   logic            w_ser_idle;
   logic            w_start;
   logic            w_done;

   // Round-robin scan: first pending requester at or after the pointer
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_sum   = '0;
      w_cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, r_ptr} + c_SUMW'(k);
         if (w_sum >= c_NREQ_W) begin
            w_sum = w_sum - c_NREQ_W;
         end
         w_cand = w_sum[IDW-1:0];
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   assign w_ptr_nxt = (w_idx == c_LAST_IDX) ? '0 : (w_idx + IDW'(1));
   assign w_din_sel = din[w_idx*DBIT +: DBIT];
   assign w_start   = w_ser_idle & w_found;

   // Grant pulse, owner, pointer and busy; a new grant in the done cycle
   // takes priority over dropping busy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gnt   <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_gnt <= '0;
         if (w_start) begin
            r_gnt   <= NREQ'(1) << w_idx;
            r_owner <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b1;
         end else if (w_done) begin
            r_busy  <= 1'b0;
         end
      end
   end

   uart_tx_scheduler_serializer #(
      .DBIT    (DBIT),
      .OS      (OS),
      .SB_TICK (SB_TICK)
   ) u_ser (
      .clk         (clk),
      .reset       (reset),
      .i_start     (w_start),
      .i_din       (w_din_sel),
      .i_s_tick    (s_tick),
      .o_tx        (tx),
      .o_done_tick (w_done),
      .o_idle      (w_ser_idle)
   );

   assign gnt       = r_gnt;
   assign owner     = r_owner;
   assign busy      = r_busy;
   assign done_tick = w_done;

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench for uart_tx_scheduler. A frame-level
//                reference model predicts grants and the tx level from the
//                number of s_tick pulses seen since each grant.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_scheduler;

   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int DBIT  = 8;
   localparam int OS    = 16;
   localparam int SB    = 16;
   localparam int TOTAL = OS * (DBIT + 1) + SB;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 s_tick;
   logic [NREQ-1:0]      req;
   logic [NREQ*DBIT-1:0] din;
   logic [NREQ-1:0]      gnt;
   logic [IDW-1:0]       owner;
   logic                 busy;
   logic                 done_tick;
   logic                 tx;

   int              errors = 0;
   int              checks = 0;
   int              tick_mode = 0;
   int              phase = 0;
   logic            cur_tick = 1'b0;
   int              ptr_m = 0;
   logic [7:0]      bytes [NREQ];
   logic [NREQ-1:0] next_mask = '0;

   uart_tx_scheduler #(
      .NREQ(NREQ), .IDW(IDW), .DBIT(DBIT), .OS(OS), .SB_TICK(SB)
   ) dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .req(req), .din(din),
      .gnt(gnt), .owner(owner), .busy(busy), .done_tick(done_tick), .tx(tx)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pack_din();
      for (int i = 0; i < NREQ; i++) din[i*DBIT +: DBIT] = bytes[i];
   endtask

   // Advance to the next negedge and choose s_tick for the upcoming edge
   task automatic next_cycle();
      @(negedge clk);
      case (tick_mode)
         0:       s_tick = ((phase % 4) == 3);
         1:       s_tick = 1'b1;
         default: s_tick = ($urandom_range(0, 3) == 0);
      endcase
      phase++;
      cur_tick = s_tick;
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic do_reset();
      next_cycle();
      reset = 1'b1;
      req   = '0;
      next_cycle();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      ptr_m = 0;
   endtask

   task automatic wait_gnt(input int budget, output int got);
      got = -1;
      for (int c = 0; c < budget; c++) begin
         next_cycle();
         if (gnt != '0) begin
            for (int i = NREQ - 1; i >= 0; i--) if (gnt[i]) got = i;
            break;
         end
         chk("idle_tx", tx, 1);
         chk("idle_busy", busy, 0);
         chk("idle_done", done_tick, 0);
      end
      chk("gnt_seen", (gnt != '0), 1);
   endtask

   // Check one frame starting in the cycle where gnt is visible
   task automatic run_frame(input int idx, input int stop_t, input int drop_t,
                            output int start_len);
      logic [7:0] eb;
      logic       exp_bit;
      int         t, k, guard;
      eb = bytes[idx];
      chk("gnt_onehot", gnt, 1 << idx);
      chk("owner", owner, idx);
      chk("busy_at_gnt", busy, 1);
      chk("start_tx", tx, 0);
      chk("done_at_gnt", done_tick, 0);
      ptr_m = (idx + 1) % NREQ;
      bytes[idx] = 8'($urandom);
      pack_din();
      req = next_mask;
      start_len = (tx === 1'b0) ? 1 : 0;
      t = cur_tick ? 1 : 0;
      guard = 0;
      while (t < stop_t && guard < 4000) begin
         next_cycle();
         guard++;
         if (drop_t >= 0 && t >= drop_t) req = '0;
         k = t / OS;
         exp_bit = (k == 0) ? 1'b0 : (k <= DBIT) ? eb[k-1] : 1'b1;
         if (k == 0 && tx === 1'b0) start_len++;
         chk("tx_bit", tx, exp_bit);
         chk("busy_frame", busy, 1);
         chk("gnt_quiet", gnt, 0);
         chk("done_early", done_tick, 0);
         if (cur_tick) t++;
      end
      chk("frame_progress", t, stop_t);
      if (stop_t >= TOTAL) begin
         next_cycle();
         chk("done_pulse", done_tick, 1);
         chk("done_tx", tx, 1);
         chk("done_busy", busy, 1);
         chk("done_owner", owner, idx);
      end
   endtask

   initial begin
      int g, e, sl;
      reset = 1'b1;
      req   = '0;
      s_tick = 1'b0;
      for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
      pack_din();
      repeat (3) next_cycle();
      chk("por_tx", tx, 1);
      chk("por_gnt", gnt, 0);
      reset = 1'b0;
      ptr_m = 0;

      // 1: idle line for 1000 clocks
      for (int c = 0; c < 1000; c++) begin
         next_cycle();
         chk("t1_tx", tx, 1);
         chk("t1_busy", busy, 0);
         chk("t1_gnt", gnt, 0);
         chk("t1_done", done_tick, 0);
      end

      // 2: single request from requester 2 carrying 8'hA5
      bytes[2] = 8'hA5;
      pack_din();
      req = 4'b0100;
      next_mask = '0;
      e = rr_pick(req, ptr_m);
      wait_gnt(10, g);
      chk("t2_owner", owner, 2);
      if (g >= 0) run_frame(e, TOTAL, -1, sl);
      next_cycle();
      chk("t2_busy_fall", busy, 0);
      chk("t2_done_once", done_tick, 0);

      // 3: all requesting, rotation 0,1,2,3,0 with one idle clock between frames
      do_reset();
      for (int i = 0; i < NREQ; i++) bytes[i] = 8'(i * 16 + $urandom_range(0, 15));
      pack_din();
      req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         e = rr_pick(req, ptr_m);
         next_mask = (f == 4) ? 4'b0000 : 4'b1111;
         wait_gnt((f == 0) ? 10 : 1, g);
         chk("t3_order", g, f % NREQ);
         if (g >= 0) run_frame(e, TOTAL, -1, sl);
      end
      next_cycle();
      chk("t3_busy_fall", busy, 0);
      chk("t3_no_gnt", gnt, 0);

      // 4: pointer after grant to 1 skips to 3, then back to 1
      do_reset();
      req = 4'b0010;
      next_mask = 4'b1010;
      wait_gnt(10, g);
      chk("t4_first", g, 1);
      if (g >= 0) run_frame(1, TOTAL, -1, sl);
      next_mask = 4'b0010;
      e = rr_pick(req, ptr_m);
      wait_gnt(1, g);
      chk("t4_second", g, 3);
      if (g >= 0) run_frame(e, TOTAL, -1, sl);
      next_mask = 4'b0000;
      e = rr_pick(req, ptr_m);
      wait_gnt(1, g);
      chk("t4_third", g, 1);
      if (g >= 0) run_frame(e, TOTAL, -1, sl);

      // 5: reset during data bit 3 forces tx high at once
      do_reset();
      bytes[2] = 8'h37;
      pack_din();
      req = 4'b0100;
      next_mask = '0;
      wait_gnt(10, g);
      if (g >= 0) run_frame(2, OS * 4 + 3, -1, sl);
      chk("t5_bit3_low", tx, 0);
      reset = 1'b1;
      #1;
      chk("t5_rst_tx", tx, 1);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_owner", owner, 0);
      ptr_m = 0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      for (int c = 0; c < 200; c++) begin
         next_cycle();
         chk("t5_no_done", done_tick, 0);
         chk("t5_idle_tx", tx, 1);
      end
      req = 4'b1001;
      e = rr_pick(req, ptr_m);
      wait_gnt(10, g);
      chk("t5_ptr_zero", g, 0);
      if (g >= 0) run_frame(e, TOTAL, -1, sl);

      // 6: continuous s_tick gives a 16-clock start bit; withdrawn request is ignored
      do_reset();
      tick_mode = 1;
      bytes[1] = 8'hC3;
      pack_din();
      req = 4'b0010;
      next_mask = '0;
      wait_gnt(10, g);
      if (g >= 0) run_frame(1, TOTAL, -1, sl);
      chk("t6_start_len", sl, 16);
      req = 4'b0100;
      next_mask = 4'b0001;
      wait_gnt(10, g);
      if (g >= 0) run_frame(2, TOTAL, OS * 5, sl);
      for (int c = 0; c < 100; c++) begin
         next_cycle();
         chk("t6_no_gnt", gnt, 0);
         chk("t6_tx_high", tx, 1);
      end

      // 7: random request masks, bytes and tick spacing
      do_reset();
      tick_mode = 2;
      req = 4'($urandom_range(1, 15));
      for (int f = 0; f < 12; f++) begin
         e = rr_pick(req, ptr_m);
         next_mask = (f == 11) ? 4'b0000 : 4'($urandom_range(1, 15));
         wait_gnt((f == 0) ? 10 : 1, g);
         chk("t7_grant", g, e);
         if (g >= 0) run_frame(e, TOTAL, -1, sl);
      end
      next_cycle();
      chk("t7_busy_fall", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_tx_scheduler
`default_nettype wire
